// File: rtl/l2_mem_bridge.sv
// L2 line request to AXI4 burst bridge: one write-back (AW/W/B) or fill (AR/R)
// in flight at a time, finished by a single-cycle mem_ack.
module l2_mem_bridge #(
  parameter int PADDR_WIDTH = 56,
  parameter int LINE_SIZE   = 64,
  parameter int BUS_WIDTH   = 64,
  parameter int BEATS       = LINE_SIZE * 8 / BUS_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_req,
  input  logic                       mem_we,
  input  logic [PADDR_WIDTH-1:0]     mem_addr,
  input  logic [LINE_SIZE*8-1:0]     mem_wdata,
  output logic                       mem_ack,
  output logic [LINE_SIZE*8-1:0]     mem_rdata,
  output logic                       mem_error,
  output logic                       m_awvalid,
  input  logic                       m_awready,
  output logic [PADDR_WIDTH-1:0]     m_awaddr,
  output logic [7:0]                 m_awlen,
  output logic [2:0]                 m_awsize,
  output logic [1:0]                 m_awburst,
  output logic                       m_wvalid,
  input  logic                       m_wready,
  output logic [BUS_WIDTH-1:0]       m_wdata,
  output logic [BUS_WIDTH/8-1:0]     m_wstrb,
  output logic                       m_wlast,
  input  logic                       m_bvalid,
  output logic                       m_bready,
  input  logic [1:0]                 m_bresp,
  output logic                       m_arvalid,
  input  logic                       m_arready,
  output logic [PADDR_WIDTH-1:0]     m_araddr,
  output logic [7:0]                 m_arlen,
  output logic [2:0]                 m_arsize,
  output logic [1:0]                 m_arburst,
  input  logic                       m_rvalid,
  output logic                       m_rready,
  input  logic [BUS_WIDTH-1:0]       m_rdata,
  input  logic [1:0]                 m_rresp,
  input  logic                       m_rlast
);

  localparam int LINE_W = LINE_SIZE * 8;
  localparam int STRB_W = BUS_WIDTH / 8;
  localparam int CNT_W  = $clog2(BEATS) + 1;
  localparam logic [CNT_W-1:0]       LAST_IDX = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]       NBEATS   = CNT_W'(BEATS);
  localparam logic [PADDR_WIDTH-1:0] OFF_MASK = PADDR_WIDTH'(LINE_SIZE - 1);
  localparam logic [7:0]             AX_LEN   = 8'(BEATS - 1);
  localparam logic [2:0]             AX_SIZE  = 3'($clog2(STRB_W));
  localparam logic [1:0]             AX_INCR  = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_ACK
  } state_e;

  state_e                 state_q, state_d;
  logic [PADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]      wdata_q, wdata_d;
  logic [LINE_W-1:0]      rbuf_q, rbuf_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [CNT_W-2:0]       beat_idx;

  assign beat_idx = cnt_q[CNT_W-2:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rbuf_d  = rbuf_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          addr_d  = mem_addr & ~OFF_MASK;
          wdata_d = mem_wdata;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = mem_we ? S_AW : S_AR;
        end
      end
      S_AW: if (m_awready) state_d = S_W;
      S_W: begin
        if (m_wready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) state_d = S_B;
        end
      end
      S_B: begin
        if (m_bvalid) begin
          err_d   = err_q | (m_bresp != 2'b00);
          state_d = S_ACK;
        end
      end
      S_AR: if (m_arready) state_d = S_R;
      S_R: begin
        if (m_rvalid) begin
          // Counter saturates at BEATS so every overflow beat stays detectable.
          if (cnt_q < NBEATS) begin
            rbuf_d[beat_idx*BUS_WIDTH +: BUS_WIDTH] = m_rdata;
            cnt_d = cnt_q + 1'b1;
          end
          err_d = err_q | (m_rresp != 2'b00) | (cnt_q >= NBEATS)
                | (m_rlast && (cnt_q != LAST_IDX));
          if (m_rlast) begin
            state_d = S_ACK;
            if (err_d) rbuf_d = '0;
          end
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Attribute fields read zero outside their own address phase.
  assign m_awvalid = (state_q == S_AW);
  assign m_awaddr  = addr_q;
  assign m_awlen   = m_awvalid ? AX_LEN  : 8'd0;
  assign m_awsize  = m_awvalid ? AX_SIZE : 3'd0;
  assign m_awburst = m_awvalid ? AX_INCR : 2'd0;

  assign m_wvalid  = (state_q == S_W);
  assign m_wdata   = wdata_q[beat_idx*BUS_WIDTH +: BUS_WIDTH];
  assign m_wstrb   = m_wvalid ? {STRB_W{1'b1}} : '0;
  assign m_wlast   = m_wvalid && (cnt_q == LAST_IDX);
  assign m_bready  = (state_q == S_B);

  assign m_arvalid = (state_q == S_AR);
  assign m_araddr  = addr_q;
  assign m_arlen   = m_arvalid ? AX_LEN  : 8'd0;
  assign m_arsize  = m_arvalid ? AX_SIZE : 3'd0;
  assign m_arburst = m_arvalid ? AX_INCR : 2'd0;
  assign m_rready  = (state_q == S_R);

  assign mem_ack   = (state_q == S_ACK);
  assign mem_error = mem_ack & err_q;
  assign mem_rdata = rbuf_q;

endmodule
